// File: rtl/fpu_addsub_arbiter_if.sv
// Requester-side and adder-side signals of the shared add/subtract arbiter.
// The arbiter connects as slave; the requesters and the adder connect as master.
interface fpu_addsub_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_op;
    logic [32*NREQ-1:0]   req_din1;
    logic [32*NREQ-1:0]   req_din2;
    logic [NREQ-1:0]      req_accept;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_result;
    logic                 rsp_error;
    logic                 busy;
    logic                 fpu_valid;
    logic [31:0]          fpu_din1;
    logic [31:0]          fpu_din2;
    logic                 fpu_ready;
    logic [31:0]          fpu_result;

    modport master (
        output req_valid, req_op, req_din1, req_din2, fpu_ready, fpu_result,
        input  req_accept, rsp_valid, rsp_result, rsp_error, busy,
               fpu_valid, fpu_din1, fpu_din2
    );

    modport slave (
        input  req_valid, req_op, req_din1, req_din2, fpu_ready, fpu_result,
        output req_accept, rsp_valid, rsp_result, rsp_error, busy,
               fpu_valid, fpu_din1, fpu_din2
    );
endinterface

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter sharing one fpu_add between NREQ requesters, with
// subtract done by flipping the sign of operand 2 and a watchdog on fpu_ready.
module fpu_addsub_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    fpu_addsub_arbiter_if.slave  bus
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   grant;
    logic [CW-1:0]   count;
    logic [31:0]     din1_q;
    logic [31:0]     din2_q;
    logic [31:0]     result_q;
    logic            error_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic            fpu_valid_q;
    logic            busy_q;

    logic            found;
    logic [GW-1:0]   gnt_idx;
    logic [31:0]     sel_din1;
    logic [31:0]     sel_din2;
    logic            sel_op;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        int j;
        found   = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req_valid[j]) begin
                found   = 1'b1;
                gnt_idx = GW'(j);
            end
        end
    end

    assign sel_din1 = bus.req_din1[32*gnt_idx +: 32];
    assign sel_din2 = bus.req_din2[32*gnt_idx +: 32];
    assign sel_op   = bus.req_op[gnt_idx];

    // Accept is combinational so operands are captured in the very cycle it pulses.
    assign bus.req_accept = (!reset && state == S_IDLE && found) ? (ONE << gnt_idx) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            count       <= '0;
            din1_q      <= '0;
            din2_q      <= '0;
            result_q    <= '0;
            error_q     <= 1'b0;
            rsp_valid_q <= '0;
            fpu_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fpu_valid_q <= 1'b0;
            rsp_valid_q <= '0;
            error_q     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant       <= gnt_idx;
                        din1_q      <= sel_din1;
                        din2_q      <= {sel_din2[31] ^ sel_op, sel_din2[30:0]};
                        fpu_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    count <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A ready on the last watchdog cycle still counts as a normal answer.
                    if (bus.fpu_ready) begin
                        result_q    <= bus.fpu_result;
                        rsp_valid_q <= ONE << grant;
                        state       <= S_RESP;
                    end else if (count == CW'(TIMEOUT - 1)) begin
                        result_q    <= QNAN;
                        error_q     <= 1'b1;
                        rsp_valid_q <= ONE << grant;
                        state       <= S_RESP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_RESP: begin
                    rr_ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + GW'(1);
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_error  = error_q;
    assign bus.busy       = busy_q;
    assign bus.fpu_valid  = fpu_valid_q;
    assign bus.fpu_din1   = din1_q;
    assign bus.fpu_din2   = din2_q;
endmodule
